// File: rtl/lu_pkg.sv
// Shared definitions for the pipelined logical unit: op encodings and accumulate FSM states.
package lu_pkg;

  localparam int unsigned LU_OP_W = 3;

  localparam logic [LU_OP_W-1:0] LU_AND     = 3'd0;
  localparam logic [LU_OP_W-1:0] LU_OR      = 3'd1;
  localparam logic [LU_OP_W-1:0] LU_XOR     = 3'd2;
  localparam logic [LU_OP_W-1:0] LU_NAND    = 3'd3;
  localparam logic [LU_OP_W-1:0] LU_NOR     = 3'd4;
  localparam logic [LU_OP_W-1:0] LU_XNOR    = 3'd5;
  localparam logic [LU_OP_W-1:0] LU_NOT_A   = 3'd6;
  localparam logic [LU_OP_W-1:0] LU_ACC_XOR = 3'd7;

  typedef enum logic {
    IDLE,
    ACCUM
  } lu_state_e;

endpackage

// File: rtl/lu_bitop.sv
// Combinational bitwise operator for ops AND..NOT_A; the accumulate op yields zero here
// because the top supplies that result itself.
module lu_bitop
  import lu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [LU_OP_W-1:0] i_op,
  output logic [WIDTH-1:0]   o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      LU_AND:   o_result = i_a & i_b;
      LU_OR:    o_result = i_a | i_b;
      LU_XOR:   o_result = i_a ^ i_b;
      LU_NAND:  o_result = ~(i_a & i_b);
      LU_NOR:   o_result = ~(i_a | i_b);
      LU_XNOR:  o_result = ~(i_a ^ i_b);
      LU_NOT_A: o_result = ~i_a;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logical unit with valid/ready handshake and a multi-beat XOR-fold mode.
// Define LU_PARITY_EN to build the registered parity flag; otherwise out_parity is tied low.
module logic_unit_pipe
  import lu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LU_OP_W-1:0] in_op,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic               out_parity
);

  lu_state_e        r_state;
  lu_state_e        w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_bitop;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;
  logic             w_is_acc;
  logic             w_load;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_zero;

  lu_bitop #(
    .WIDTH(WIDTH)
  ) u_bitop (
    .i_a     (in_a),
    .i_b     (in_b),
    .i_op    (in_op),
    .o_result(w_bitop)
  );

  // Ready depends only on the output slot, so accumulate beats also stall under back-pressure.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_is_acc = (in_op == LU_ACC_XOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept && w_is_acc) begin
      case (r_state)
        IDLE:    if (!in_last) w_state_next = ACCUM;
        ACCUM:   if (in_last) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Non-accumulate ops pass through without disturbing the fold in progress.
  always_comb begin
    w_load     = 1'b0;
    w_result   = w_bitop;
    w_acc_next = r_acc;
    if (w_accept) begin
      if (!w_is_acc) begin
        w_load = 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (in_last) begin
              w_load   = 1'b1;
              w_result = in_a;
            end else begin
              w_acc_next = in_a;
            end
          end
          ACCUM: begin
            if (in_last) begin
              w_load     = 1'b1;
              w_result   = r_acc ^ in_a;
              w_acc_next = '0;
            end else begin
              w_acc_next = r_acc ^ in_a;
            end
          end
          default: w_acc_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zero  <= 1'b1;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_zero  <= (w_result == '0);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef LU_PARITY_EN
  logic r_out_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_parity <= 1'b0;
    end else if (w_load) begin
      r_out_parity <= ^w_result;
    end
  end

  assign out_parity = r_out_parity;
`else
  assign out_parity = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zero  = r_out_zero;

endmodule
